// File: rtl/regbank_write_port_pkg.sv
// Shared defaults and state encoding for the register-bank write port.
package regbank_write_port_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int ZERO_REG_DEF   = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regbank_write_port_addr_decoder.sv
// Binary address to one-hot enable decoder; en=0 forces all outputs low.
module regbank_write_port_addr_decoder #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic                       en,
  output logic [(2**ADDR_WIDTH)-1:0] onehot
);

  for (genvar gi = 0; gi < 2**ADDR_WIDTH; gi++) begin : g_dec
    assign onehot[gi] = en && (addr == ADDR_WIDTH'(gi));
  end

endmodule

// File: rtl/regbank_write_port.sv
// Register bank write side: byte-masked writes, flat register export and a
// one-register-per-cycle clear sweep.
module regbank_write_port
  import regbank_write_port_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ZERO_REG   = ZERO_REG_DEF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [ADDR_WIDTH-1:0]                  wr_addr,
  input  logic [DATA_WIDTH-1:0]                  wr_data,
  input  logic [DATA_WIDTH/8-1:0]                wr_byte_en,
  output logic                                   wr_done,
  input  logic                                   clr_req,
  output logic                                   busy,
  output logic                                   clr_done,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  reg_flat
);

  localparam int NUM_REGS  = 2**ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt_reg, clr_cnt_next;
  logic                    wr_done_reg;
  logic                    clr_done_reg, clr_done_next;
  logic                    wr_accept;
  logic [NUM_REGS-1:0]     wr_onehot;

  assign wr_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == CLEAR);
  assign wr_done   = wr_done_reg;
  assign clr_done  = clr_done_reg;
  assign wr_accept = wr_valid && (state_reg == IDLE);

  regbank_write_port_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_decoder (
    .addr   (wr_addr),
    .en     (wr_accept),
    .onehot (wr_onehot)
  );

  always_comb begin
    state_next    = state_reg;
    clr_cnt_next  = clr_cnt_reg;
    clr_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        // Counter parks on the last index; it only restarts on CLEAR entry.
        if (clr_cnt_reg == LAST_IDX) begin
          state_next    = IDLE;
          clr_done_next = 1'b1;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      clr_cnt_reg  <= '0;
      wr_done_reg  <= 1'b0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      wr_done_reg  <= wr_accept;
      clr_done_reg <= clr_done_next;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  clr_hit;

    assign clr_hit = (state_reg == CLEAR) && (clr_cnt_reg == ADDR_WIDTH'(gi));

    // Writes only land in IDLE, so a clear hit and a write never coincide.
    always_ff @(posedge clk) begin
      if (reset || IS_ZERO) begin
        data_reg <= '0;
      end else if (clr_hit) begin
        data_reg <= '0;
      end else if (wr_onehot[gi]) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (wr_byte_en[b]) begin
            data_reg[8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end

    assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
  end

endmodule

// File: tb/tb_regbank_write_port.sv
// Self-checking bench for regbank_write_port: directed vector table, multi-cycle
// clear scenarios and a randomized run against a time-based reference model.
module tb_regbank_write_port;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_byte_en;
  logic          wr_done;
  logic          clr_req;
  logic          busy;
  logic          clr_done;
  logic [1023:0] reg_flat;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  regbank_write_port dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_byte_en (wr_byte_en),
    .wr_done    (wr_done),
    .clr_req    (clr_req),
    .busy       (busy),
    .clr_done   (clr_done),
    .reg_flat   (reg_flat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_reg(input int k);
    return reg_flat[k*32 +: 32];
  endfunction

  // Reference write: byte-wise merge, register 0 is always zero.
  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    model[0] = 32'h0;
  endtask

  task automatic model_zero();
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
  endtask

  task automatic check_bank(input string name);
    int nbad;
    nbad = 0;
    for (int k = 0; k < 32; k++) begin
      if (dut_reg(k) !== model[k]) begin
        if (nbad == 0)
          $display("  bank %s: reg %0d is %h, model %h", name, k, dut_reg(k), model[k]);
        nbad++;
      end
    end
    check(name, nbad, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_byte_en = '0;
    clr_req    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    model_zero();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_byte_en = be;
    tick();
    wr_valid = 1'b0;
    model_write(int'(a), d, be);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check({name, "_timeout"}, 32'(busy), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();

    check("rst_wr_ready", 32'(wr_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr_done", 32'(wr_done), 32'h0);
    check("rst_clr_done", 32'(clr_done), 32'h0);
    reset = 1'b0;
    model_zero();
    check_bank("rst_bank");

    // Directed table: each row is one write and the expected register value.
    vecs[0] = '{addr: 5'd5,  data: 32'hDEADBEEF, be: 4'hF,    exp: 32'hDEADBEEF};
    vecs[1] = '{addr: 5'd7,  data: 32'h11223344, be: 4'hF,    exp: 32'h11223344};
    vecs[2] = '{addr: 5'd7,  data: 32'hAABBCCDD, be: 4'b0101, exp: 32'h11BB33DD};
    vecs[3] = '{addr: 5'd0,  data: 32'hFFFFFFFF, be: 4'hF,    exp: 32'h00000000};
    vecs[4] = '{addr: 5'd9,  data: 32'h12345678, be: 4'h0,    exp: 32'h00000000};
    vecs[5] = '{addr: 5'd9,  data: 32'hCAFEF00D, be: 4'b1010, exp: 32'hCA00F000};
    vecs[6] = '{addr: 5'd31, data: 32'h0BADF00D, be: 4'hF,    exp: 32'h0BADF00D};
    vecs[7] = '{addr: 5'd31, data: 32'h77777777, be: 4'b1000, exp: 32'h77ADF00D};

    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
      $display("write addr=%0d data=%h be=%b -> reg=%h wr_done=%0b",
               vecs[i].addr, vecs[i].data, vecs[i].be, dut_reg(int'(vecs[i].addr)), wr_done);
      check($sformatf("vec%0d_wr_done", i), 32'(wr_done), 32'h1);
      check($sformatf("vec%0d_reg", i), dut_reg(int'(vecs[i].addr)), vecs[i].exp);
    end
    tick();
    check("wr_done_one_cycle", 32'(wr_done), 32'h0);
    check_bank("table_bank");

    // Back-to-back writes to the same address: last one wins.
    wr_valid = 1'b1; wr_addr = 5'd12; wr_byte_en = 4'hF; wr_data = 32'h00000001;
    tick();
    wr_data = 32'h00000002;
    tick();
    wr_valid = 1'b0;
    check("b2b_wr_done", 32'(wr_done), 32'h1);
    check("b2b_last_wins", dut_reg(12), 32'h00000002);
    model_write(12, 32'h2, 4'hF);
    $display("back-to-back addr=12 -> reg=%h", dut_reg(12));

    // Fill 1..31, then clear with a write held pending through the sweep.
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'h10000000 + 32'(i) * 32'h01010101, 4'hF);
    tick();
    check_bank("fill_bank");
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd12; wr_data = 32'h5A5A5A5A; wr_byte_en = 4'hF;
    begin
      int cycles, ready_seen, done_seen;
      cycles = 0; ready_seen = 0; done_seen = 0;
      while (busy === 1'b1 && cycles < 100) begin
        if (wr_ready !== 1'b0) ready_seen++;
        if (clr_done !== 1'b0) done_seen++;
        tick();
        cycles++;
      end
      check("clr_busy_cycles", cycles, 32);
      check("clr_wr_ready_low", ready_seen, 0);
      check("clr_no_early_done", done_seen, 0);
    end
    check("clr_done_pulse", 32'(clr_done), 32'h1);
    check("clr_ready_back", 32'(wr_ready), 32'h1);
    model_zero();
    check_bank("clr_bank");
    tick();
    wr_valid = 1'b0;
    model_write(12, 32'h5A5A5A5A, 4'hF);
    $display("clear sweep done, pending write addr=12 -> reg=%h", dut_reg(12));
    check("pending_wr_done", 32'(wr_done), 32'h1);
    check("clr_done_once", 32'(clr_done), 32'h0);
    check_bank("pending_bank");

    // Simultaneous write and clear request.
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h5; wr_byte_en = 4'hF; clr_req = 1'b1;
    tick();
    idle_inputs();
    check("wc_wr_done", 32'(wr_done), 32'h1);
    check("wc_busy", 32'(busy), 32'h1);
    check("wc_reg3_written", dut_reg(3), 32'h5);
    tick(); tick(); tick();
    check("wc_reg3_before_sweep", dut_reg(3), 32'h5);
    tick();
    check("wc_reg3_swept", dut_reg(3), 32'h0);
    $display("write+clear addr=3 -> reg3 after sweep=%h", dut_reg(3));
    wait_idle("wc");
    model_zero();
    check_bank("wc_bank");

    // Reset in the middle of a sweep aborts it without clr_done.
    do_write(5'd20, 32'hFEEDFACE, 4'hF);
    do_write(5'd2, 32'h01020304, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", 32'(busy), 32'h1);
    check("mid_reg20_untouched", dut_reg(20), 32'hFEEDFACE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_zero();
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_ready", 32'(wr_ready), 32'h1);
    check("abort_clr_done", 32'(clr_done), 32'h0);
    check_bank("abort_bank");
    tick();
    check("abort_clr_done_late", 32'(clr_done), 32'h0);
    $display("reset mid-sweep -> busy=%0b wr_ready=%0b", busy, wr_ready);

    // Randomized run against a time-indexed model of the clear sweep.
    do_reset();
    begin
      int cyc, clr_start, k, k2;
      bit pend, in_clear, exp_wd, exp_cd;
      cyc = 0; clr_start = -1000; pend = 0;
      for (int it = 0; it < 600; it++) begin
        if (!pend) begin
          wr_valid   = 1'($urandom_range(0, 1));
          wr_addr    = 5'($urandom_range(0, 31));
          wr_data    = $urandom;
          wr_byte_en = 4'($urandom_range(0, 15));
        end
        clr_req = ($urandom_range(0, 39) == 0);
        // The sweep entered at edge clr_start covers edges clr_start+1 .. +32.
        k = cyc - clr_start;
        in_clear = (k >= 1 && k <= 32);
        check("rnd_wr_ready", 32'(wr_ready), 32'(!in_clear));
        exp_wd = wr_valid && !in_clear;
        exp_cd = (k == 32);
        if (in_clear) begin
          model[k - 1] = 32'h0;
        end else begin
          if (wr_valid) model_write(int'(wr_addr), wr_data, wr_byte_en);
          if (clr_req) clr_start = cyc;
        end
        tick();
        cyc++;
        k2 = cyc - clr_start;
        if (exp_wd)
          $display("rnd write addr=%0d data=%h be=%b -> reg=%h", wr_addr, wr_data, wr_byte_en,
                   dut_reg(int'(wr_addr)));
        check("rnd_wr_done", 32'(wr_done), 32'(exp_wd));
        check("rnd_clr_done", 32'(clr_done), 32'(exp_cd));
        check("rnd_busy", 32'(busy), 32'(k2 >= 1 && k2 <= 32));
        check_bank("rnd_bank");
        pend = wr_valid && !exp_wd;
      end
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbank_write_port.md
Name: regbank_write_port

Overview:
- Write-side counterpart to the register-file read-select trees.
- Holds a 32 x 32-bit register bank.
- Decodes a write address to one-hot enables and commits byte-masked writes.
- Exposes every register on a flat bus that feeds the downstream read muxes.
- Includes a sequenced clear-all engine that zeroes the bank one register per cycle, for pipeline flush and CPU reset.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, write address width.
- NUM_REGS, 2**ADDR_WIDTH, register count; derived, not overridden.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- wr_valid  input  1  write request.
- wr_ready  output  1  write can be accepted this cycle.
- wr_addr  input  ADDR_WIDTH  target register.
- wr_data  input  DATA_WIDTH  write data.
- wr_byte_en  input  DATA_WIDTH/8  per-byte write enable; bit i covers data[8i+7:8i].
- wr_done  output  1  one-cycle pulse, the cycle after a write is accepted.
- clr_req  input  1  request a clear of the whole bank.
- busy  output  1  clear in progress.
- clr_done  output  1  one-cycle pulse when the clear finishes.
- reg_flat  output  NUM_REGS*DATA_WIDTH  all registers; reg k is at [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset, on the clk edge while reset=1:
  - all registers go to 0;
  - state goes to IDLE and the clear counter to 0;
  - wr_done=0, clr_done=0, busy=0;
  - wr_ready=1 once state is IDLE.
- Reset has priority over every other input. Reset mid-clear aborts the clear; there is no clr_done pulse.
- States: IDLE and CLEAR.
- wr_ready is combinational and equals (state==IDLE). busy equals (state==CLEAR).
- Write accept: a write is accepted when wr_valid && wr_ready at a rising edge.
  - At that edge, reg[wr_addr] byte i takes wr_data byte i wherever wr_byte_en[i]=1. Other bytes and other registers hold.
  - The new value is visible on reg_flat the cycle after the edge (latency 1).
  - wr_done=1 for exactly that following cycle.
- Writes to address 0 with ZERO_REG=1 are accepted and produce wr_done, but reg 0 stays 0.
- wr_byte_en=0 is accepted, produces wr_done, and changes no data.
- Back-to-back writes every cycle are allowed. Writes to the same address apply in order, the last one wins.
- IDLE -> CLEAR when clr_req=1 at an edge. The clear counter is set to 0.
- If wr_valid and clr_req are both high in the same IDLE cycle:
  - the write is accepted and committed, with wr_done next cycle;
  - CLEAR is entered at the same edge;
  - the written register is zeroed later by the clear sweep.
- In CLEAR, each edge zeroes reg[counter] and then increments counter. The sweep takes NUM_REGS cycles (32 by default).
- The edge that zeroes reg NUM_REGS-1 returns state to IDLE, and clr_done=1 for the next cycle.
- clr_req in CLEAR is ignored and does not restart the sweep.
- wr_valid in CLEAR is not accepted: wr_ready=0. The requester holds addr/data/byte_en until accepted.
- clr_req held continuously restarts a clear immediately after each return to IDLE. Writes get a chance only in IDLE cycles.
- Counter wraps from NUM_REGS-1 to 0 only via the IDLE->CLEAR entry, never mid-sweep.
- The register bank has no read-side logic; selection is done downstream.

Decomposition:
- Shared package/header holds:
  - DATA_WIDTH and ADDR_WIDTH defaults;
  - state encodings IDLE=1'b0, CLEAR=1'b1;
  - the ZERO_REG default.
- One sub-module: addr_decoder. Inputs are a 5-bit addr and an en bit; output is a 32-bit one-hot. en=0 gives all zeros.
- The top level uses addr_decoder for write enables and a separate compare for the clear index.

Test Plan:
1. Reset, then write addr 5, data 0xDEADBEEF, byte_en 4'hF -> wr_done at T+1; reg_flat[5] = 0xDEADBEEF at T+1; all other regs 0.
2. With reg 7 = 0x11223344, write byte_en 4'b0101 and data 0xAABBCCDD -> reg 7 = 0x11BB33DD.
3. Write addr 0, data 0xFFFFFFFF -> wr_done=1; reg 0 stays 0.
4. Fill regs 1..31 with nonzero values, pulse clr_req, hold wr_valid during the sweep:
   - busy=1 for 32 cycles and wr_ready=0 throughout;
   - clr_done pulses once;
   - all regs 0;
   - the pending write is accepted in the first IDLE cycle after the sweep.
5. wr_valid to addr 3, data 0x5, and clr_req in the same IDLE cycle -> wr_done=1 and reg 3=5 for the cycles before the sweep reaches index 3, then reg 3=0.
6. Assert reset at sweep cycle 10 -> next cycle: state IDLE, busy=0, no clr_done, all regs 0, wr_ready=1.
